// File: rtl/argmax_layer.sv
`default_nettype none
// ============================================================================
// Module      : argmax_layer
// Description : Sequential arg-max over NUM_CLASSES signed scores, one class per
//               cycle, reporting winner, its score, a saturated margin over the
//               runner-up and a low-confidence flag.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_layer #(
  parameter int                            DATA_WIDTH       = 32,
  parameter int                            FRACTION         = 24,
  parameter int                            NUM_CLASSES      = 2,
  parameter logic signed [DATA_WIDTH-1:0]  MARGIN_THRESHOLD = '0,
  localparam int                           CLASS_W          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   argmax_layer_ready_in,
  input  logic [NUM_CLASSES-1:0] argmax_layer_valid_in,
  input  logic [DATA_WIDTH-1:0]  argmax_layer_data_in [0:NUM_CLASSES-1],
  input  logic                   argmax_layer_ready_out,
  output logic                   argmax_layer_valid_out,
  output logic [CLASS_W-1:0]     argmax_layer_class,
  output logic [DATA_WIDTH-1:0]  argmax_layer_max,
  output logic [DATA_WIDTH-1:0]  argmax_layer_margin,
  output logic                   argmax_layer_low_conf
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CLASS_W-1:0]    LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  // FRACTION only documents the fixed-point format; reject nonsensical values.
  generate
    if (NUM_CLASSES < 1 || FRACTION < 0 || FRACTION >= DATA_WIDTH) begin : g_param_check
      $error("argmax_layer: invalid NUM_CLASSES/FRACTION parameters");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   scores_q [0:NUM_CLASSES-1];
  logic [DATA_WIDTH-1:0]   scores_d [0:NUM_CLASSES-1];
  logic [DATA_WIDTH-1:0]   best_val_q, best_val_d;
  logic [CLASS_W-1:0]      best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0]   runner_q, runner_d;
  logic [CLASS_W-1:0]      idx_q, idx_d;
  logic                    valid_out_q, valid_out_d;
  logic [CLASS_W-1:0]      class_q, class_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [DATA_WIDTH-1:0]   margin_q, margin_d;
  logic                    low_conf_q, low_conf_d;

  logic [DATA_WIDTH-1:0]   score;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0]   margin_fin;

  always_comb begin
    state_d     = state_q;
    scores_d    = scores_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    runner_d    = runner_q;
    idx_d       = idx_q;
    valid_out_d = valid_out_q;
    class_d     = class_q;
    max_d       = max_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;
    score       = scores_q[idx_q];
    diff        = '0;
    margin_fin  = '0;

    case (state_q)
      IDLE: begin
        if (&argmax_layer_valid_in) begin
          scores_d   = argmax_layer_data_in;
          best_val_d = argmax_layer_data_in[0];
          best_idx_d = '0;
          runner_d   = MOST_NEG;
          idx_d      = CLASS_W'(1);
          if (NUM_CLASSES == 1) begin
            // No runner-up exists, so the margin is pinned at full scale.
            class_d     = '0;
            max_d       = argmax_layer_data_in[0];
            margin_d    = MAX_POS;
            low_conf_d  = $signed(MAX_POS) < $signed(MARGIN_THRESHOLD);
            valid_out_d = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        // Strictly-greater keeps the lowest index on ties.
        if ($signed(score) > $signed(best_val_q)) begin
          runner_d   = best_val_q;
          best_val_d = score;
          best_idx_d = idx_q;
        end else if ($signed(score) > $signed(runner_q)) begin
          runner_d = score;
        end

        if (idx_q == LAST_IDX) begin
          diff       = $signed({best_val_d[DATA_WIDTH-1], best_val_d})
                     - $signed({runner_d[DATA_WIDTH-1], runner_d});
          margin_fin = (diff > $signed({1'b0, MAX_POS})) ? MAX_POS : diff[DATA_WIDTH-1:0];
          class_d     = best_idx_d;
          max_d       = best_val_d;
          margin_d    = margin_fin;
          low_conf_d  = $signed(margin_fin) < $signed(MARGIN_THRESHOLD);
          valid_out_d = 1'b1;
          state_d     = OUT;
        end else begin
          idx_d = idx_q + CLASS_W'(1);
        end
      end

      OUT: begin
        if (argmax_layer_ready_out) begin
          valid_out_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        valid_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scores_q    <= '{default: '0};
      best_val_q  <= '0;
      best_idx_q  <= '0;
      runner_q    <= '0;
      idx_q       <= '0;
      valid_out_q <= 1'b0;
      class_q     <= '0;
      max_q       <= '0;
      margin_q    <= '0;
      low_conf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scores_q    <= scores_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      runner_q    <= runner_d;
      idx_q       <= idx_d;
      valid_out_q <= valid_out_d;
      class_q     <= class_d;
      max_q       <= max_d;
      margin_q    <= margin_d;
      low_conf_q  <= low_conf_d;
    end
  end

  assign argmax_layer_ready_in  = (state_q == IDLE) && !rst;
  assign argmax_layer_valid_out = valid_out_q;
  assign argmax_layer_class     = class_q;
  assign argmax_layer_max       = max_q;
  assign argmax_layer_margin    = margin_q;
  assign argmax_layer_low_conf  = low_conf_q;

endmodule
`default_nettype wire

// File: tb/tb_argmax_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_layer
// Description : Directed self-checking bench for argmax_layer (16-bit, 4 classes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_layer;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready_in;
  logic [NC-1:0] valid_in = '0;
  logic [DW-1:0] data_in [0:NC-1];
  logic          ready_out = 1'b0;
  logic          valid_out;
  logic [CW-1:0] cls;
  logic [DW-1:0] mx;
  logic [DW-1:0] mg;
  logic          low;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  argmax_layer #(
    .DATA_WIDTH       (16),
    .FRACTION         (8),
    .NUM_CLASSES      (4),
    .MARGIN_THRESHOLD (16'sh0080)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .argmax_layer_ready_in  (ready_in),
    .argmax_layer_valid_in  (valid_in),
    .argmax_layer_data_in   (data_in),
    .argmax_layer_ready_out (ready_out),
    .argmax_layer_valid_out (valid_out),
    .argmax_layer_class     (cls),
    .argmax_layer_max       (mx),
    .argmax_layer_margin    (mg),
    .argmax_layer_low_conf  (low)
  );

  // Stimulus only: waits for ready_in, presents one vector, returns edges until valid_out
  // (-1 = no result within budget, -2 = never ready).
  task automatic run_vector(input logic [DW-1:0] s0, s1, s2, s3, output int lat);
    int w;
    w = 0;
    while (ready_in !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    data_in[0] = s0; data_in[1] = s1; data_in[2] = s2; data_in[3] = s3;
    valid_in = '1;
    @(posedge clk); #1;
    valid_in = '0;
    lat = (w >= 20) ? -2 : -1;
    if (lat == -1) begin
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (valid_out === 1'b1) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic do_handshake();
    ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    total++;
    if ({valid_out, cls, mx, mg, low, ready_in} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b class=%0d max=%h margin=%h low=%b ready_in=%b required all zero",
               valid_out, cls, mx, mg, low, ready_in);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++;
    if (ready_in !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_in: got %b required 1", ready_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_vector(16'h0100, 16'h0300, 16'hFF00, 16'h0200, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL basic_latency: got %0d required 3", lat); end
    total++;
    if ({valid_out, cls, mx, mg, low} !== {1'b1, 2'd1, 16'h0300, 16'h0100, 1'b0}) begin
      bad++;
      $display("FAIL basic_result: valid=%b class=%0d max=%h margin=%h low=%b required 1/1/0300/0100/0",
               valid_out, cls, mx, mg, low);
    end
    do_handshake();
    total++;
    if ({valid_out, ready_in} !== 2'b01) begin
      bad++;
      $display("FAIL basic_handshake: valid=%b ready_in=%b required 0/1", valid_out, ready_in);
    end
    total++;
    if ({cls, mx, mg, low} !== {2'd1, 16'h0300, 16'h0100, 1'b0}) begin
      bad++;
      $display("FAIL basic_retain: class=%0d max=%h margin=%h low=%b required 1/0300/0100/0",
               cls, mx, mg, low);
    end
  endtask

  task automatic test_tie();
    int lat;
    run_vector(16'h0200, 16'h0200, 16'h0000, 16'h0000, lat);
    total++;
    if ({lat == 3, valid_out, cls, mx, mg, low} !== {1'b1, 1'b1, 2'd0, 16'h0200, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL tie_result: lat=%0d valid=%b class=%0d max=%h margin=%h low=%b required 3/1/0/0200/0000/1",
               lat, valid_out, cls, mx, mg, low);
    end
    do_handshake();
  endtask

  task automatic test_negative();
    int lat;
    run_vector(16'h8000, 16'hFFFF, 16'h8001, 16'hFFFE, lat);
    total++;
    if ({lat == 3, valid_out, cls, mx, mg, low} !== {1'b1, 1'b1, 2'd1, 16'hFFFF, 16'h0001, 1'b1}) begin
      bad++;
      $display("FAIL negative_result: lat=%0d valid=%b class=%0d max=%h margin=%h low=%b required 3/1/1/FFFF/0001/1",
               lat, valid_out, cls, mx, mg, low);
    end
    do_handshake();
  endtask

  task automatic test_saturation();
    int lat;
    run_vector(16'h7FFF, 16'h8000, 16'h8000, 16'h8000, lat);
    total++;
    if ({lat == 3, valid_out, cls, mx, mg, low} !== {1'b1, 1'b1, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0}) begin
      bad++;
      $display("FAIL saturation_result: lat=%0d valid=%b class=%0d max=%h margin=%h low=%b required 3/1/0/7FFF/7FFF/0",
               lat, valid_out, cls, mx, mg, low);
    end
    do_handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    run_vector(16'h0100, 16'h0300, 16'hFF00, 16'h0200, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL bp_latency: got %0d required 3", lat); end
    for (int i = 0; i < 5; i++) begin
      data_in[0] = 16'h7000; data_in[1] = 16'h0000; data_in[2] = 16'h1234; data_in[3] = 16'h8000;
      valid_in = '1;
      @(posedge clk); #1;
      total++;
      if ({valid_out, ready_in, cls, mx, mg, low} !== {1'b1, 1'b0, 2'd1, 16'h0300, 16'h0100, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready_in=%b class=%0d max=%h margin=%h low=%b required 1/0/1/0300/0100/0",
                 i, valid_out, ready_in, cls, mx, mg, low);
      end
    end
    valid_in = '0;
    do_handshake();
    total++;
    if ({valid_out, ready_in} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: valid=%b ready_in=%b required 0/1", valid_out, ready_in);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid_out, ready_in} !== 2'b01) begin
      bad++;
      $display("FAIL bp_no_second_accept: valid=%b ready_in=%b required 0/1", valid_out, ready_in);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    data_in[0] = 16'h0500; data_in[1] = 16'h0600; data_in[2] = 16'h0700; data_in[3] = 16'h0100;
    valid_in = '1;
    @(posedge clk); #1;
    valid_in = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if ({valid_out, cls, mx, mg, low, ready_in} !== '0) begin
      bad++;
      $display("FAIL midscan_reset: valid=%b class=%0d max=%h margin=%h low=%b ready_in=%b required all zero",
               valid_out, cls, mx, mg, low, ready_in);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL midscan_no_valid: got %b required 0", valid_out);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ready_in !== 1'b1) begin
      bad++;
      $display("FAIL midscan_ready_in: got %b required 1", ready_in);
    end
    run_vector(16'h0100, 16'h0300, 16'hFF00, 16'h0200, lat);
    total++;
    if ({lat == 3, valid_out, cls, mx, mg, low} !== {1'b1, 1'b1, 2'd1, 16'h0300, 16'h0100, 1'b0}) begin
      bad++;
      $display("FAIL midscan_recover: lat=%0d valid=%b class=%0d max=%h margin=%h low=%b required 3/1/1/0300/0100/0",
               lat, valid_out, cls, mx, mg, low);
    end
    do_handshake();
  endtask

  initial begin
    for (int i = 0; i < NC; i++) data_in[i] = '0;
    test_reset();
    test_basic();
    test_tie();
    test_negative();
    test_saturation();
    test_backpressure();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
